// File: rtl/num_classifier_seq_pkg.sv
// num_classifier_seq_pkg: FSM state encoding and operand width limits for the classifier.
package num_classifier_seq_pkg;
  typedef enum logic [1:0] {IDLE, MODK, TRIAL, DONE} state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;
endpackage

// File: rtl/num_classifier_seq_mod_serial.sv
// mod_serial: restoring bit-serial remainder, one load cycle then WIDTH shift-subtract cycles.
module mod_serial #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             rdy
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] r_rem, r_q, r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_rdy;
  logic [WIDTH:0]   w_trial, w_sub;
  logic [WIDTH-1:0] w_rem_n;
  assign w_trial = {r_rem, r_q[WIDTH-1]};
  assign w_sub   = w_trial - {1'b0, r_div};
  assign w_rem_n = (w_trial >= {1'b0, r_div}) ? w_sub[WIDTH-1:0] : w_trial[WIDTH-1:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_q   <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (load) begin
        r_rem <= '0;
        r_q   <= dividend;
        r_div <= divisor;
        r_cnt <= CW'(WIDTH);
      end else if (r_cnt != '0) begin
        r_rem <= w_rem_n;
        r_q   <= r_q << 1;
        r_cnt <= r_cnt - 1'b1;
        r_rdy <= (r_cnt == CW'(1));
      end
    end
  end
  assign rem = r_rem;
  assign rdy = r_rdy;
endmodule

// File: rtl/num_classifier_seq.sv
// num_classifier_seq: sequential prime / divisible-by-DIV_K / even classifier using trial division.
module num_classifier_seq
  import num_classifier_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DIV_K = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic             prime,
  output logic             div_k,
  output logic             even
);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("num_classifier_seq: WIDTH out of range");
  end
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_n, r_d, w_d_n, w_rem, w_divisor;
  logic             r_go, r_dk, r_prime, r_div_k, r_even;
  logic             w_accept, w_rdy, w_issue, w_decide, w_prime_n, w_dk, w_over;
  logic [WIDTH:0]   w_cand;
  logic [2*WIDTH+1:0] w_ce, w_sq;
  assign w_accept = (r_state == IDLE) && start;
  assign w_dk     = (r_state == MODK) ? (w_rem == '0) : r_dk;
  // next trial divisor: 3 right after the DIV_K op, otherwise d+2; squared wide so it never overflows
  assign w_cand   = (r_state == MODK) ? (WIDTH+1)'(3) : {1'b0, r_d} + (WIDTH+1)'(2);
  assign w_ce     = {{(WIDTH+1){1'b0}}, w_cand};
  assign w_sq     = w_ce * w_ce;
  assign w_over   = w_sq > {{(WIDTH+2){1'b0}}, r_n};
  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_decide  = 1'b0;
    w_prime_n = 1'b0;
    w_d_n     = r_d;
    case (r_state)
      IDLE:  w_state_n = start ? MODK : IDLE;
      MODK:
        if (w_rdy) begin
          if (r_n < WIDTH'(2) || !r_n[0]) begin
            w_decide  = 1'b1;
            w_prime_n = (r_n == WIDTH'(2));
          end else if (r_n < WIDTH'(4) || w_over) begin
            w_decide  = 1'b1;
            w_prime_n = 1'b1;
          end else begin
            w_issue   = 1'b1;
            w_d_n     = w_cand[WIDTH-1:0];
            w_state_n = TRIAL;
          end
        end
      TRIAL:
        if (w_rdy) begin
          if (w_rem == '0) begin
            w_decide = 1'b1;
          end else if (w_over) begin
            w_decide  = 1'b1;
            w_prime_n = 1'b1;
          end else begin
            w_issue = 1'b1;
            w_d_n   = w_cand[WIDTH-1:0];
          end
        end
      default: w_state_n = IDLE;
    endcase
    if (w_decide) w_state_n = DONE;
  end
  assign w_divisor = w_issue ? w_cand[WIDTH-1:0] : WIDTH'(DIV_K);
  mod_serial #(.WIDTH(WIDTH)) u_mod (
    .clk      (clk),
    .reset    (reset),
    .load     (r_go | w_issue),
    .dividend (r_n),
    .divisor  (w_divisor),
    .rem      (w_rem),
    .rdy      (w_rdy)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_d     <= '0;
      r_go    <= 1'b0;
      r_dk    <= 1'b0;
      r_prime <= 1'b0;
      r_div_k <= 1'b0;
      r_even  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_go    <= w_accept;
      r_d     <= w_d_n;
      if (w_accept) r_n <= n_in;
      if (r_state == MODK && w_rdy) r_dk <= (w_rem == '0);
      if (w_decide) begin
        r_prime <= w_prime_n;
        r_div_k <= w_dk;
        r_even  <= ~r_n[0];
      end
    end
  end
  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign prime = r_prime;
  assign div_k = r_div_k;
  assign even  = r_even;
endmodule

// File: tb/tb_num_classifier_seq.sv
// tb_num_classifier_seq: directed table plus exhaustive sweep and reset/ignored-start sequences.
module tb_num_classifier_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] n_in = '0;
  logic       busy, done, prime, div_k, even;
  int tests = 0;
  int fails = 0;

  num_classifier_seq #(.WIDTH(5), .DIV_K(3)) dut (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in),
    .busy(busy), .done(done), .prime(prime), .div_k(div_k), .even(even)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int p;
    int dk;
    int ev;
    int lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Operation count of the trial-division procedure, independent of the DUT.
  function automatic int mod_ops(input int n);
    int m, d;
    if (n < 4 || n % 2 == 0) return 1;
    m = 1;
    d = 3;
    while (d * d <= n) begin
      m++;
      if (n % d == 0) break;
      d += 2;
    end
    return m;
  endfunction

  task automatic classify(input int n, input int ep, input int ed, input int ee,
                          input int el, input int ign_at = -1);
    int k;
    @(negedge clk);
    n_in = 5'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk($sformatf("busy_after_accept n=%0d", n), busy, 1);
    k = 0;
    while (!done && k < 400) begin
      if (k == ign_at) begin
        @(negedge clk);
        n_in = 5'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_in = 5'(n);
        @(posedge clk);
        k += 2;
      end else begin
        @(posedge clk);
        k++;
      end
      #1;
    end
    chk($sformatf("latency n=%0d", n), k, el);
    chk($sformatf("busy_at_done n=%0d", n), busy, 1);
    chk($sformatf("prime n=%0d", n), prime, ep);
    chk($sformatf("div_k n=%0d", n), div_k, ed);
    chk($sformatf("even n=%0d", n), even, ee);
    @(posedge clk);
    #1;
    chk($sformatf("done_one_cycle n=%0d", n), done, 0);
    chk($sformatf("prime_held n=%0d", n), prime, ep);
  endtask

  vec_t vecs[11];
  logic [31:0] prime_mask;
  int seen_done;

  initial begin
    vecs[0]  = '{0, 0, 1, 1, 7};
    vecs[1]  = '{1, 0, 0, 0, 7};
    vecs[2]  = '{2, 1, 0, 1, 7};
    vecs[3]  = '{3, 1, 1, 0, 7};
    vecs[4]  = '{5, 1, 0, 0, 7};
    vecs[5]  = '{9, 0, 1, 0, 13};
    vecs[6]  = '{11, 1, 0, 0, 13};
    vecs[7]  = '{15, 0, 1, 0, 13};
    vecs[8]  = '{25, 0, 0, 0, 19};
    vecs[9]  = '{29, 1, 0, 0, 19};
    vecs[10] = '{31, 1, 0, 0, 19};
    prime_mask = 32'hA08A28AC;

    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_prime", prime, 0);
    chk("reset_div_k", div_k, 0);
    chk("reset_even", even, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      classify(vecs[i].n, vecs[i].p, vecs[i].dk, vecs[i].ev, vecs[i].lat);

    for (int n = 0; n < 32; n++)
      classify(n, int'(prime_mask[n]), (n % 3 == 0) ? 1 : 0, (n % 2 == 0) ? 1 : 0,
               mod_ops(n) * 6 + 1);

    classify(29, 1, 0, 0, 19, 3);

    @(negedge clk);
    n_in = 5'd29;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen_done = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_in = 5'd6;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      seen_done |= int'(done);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prime", prime, 0);
    chk("abort_div_k", div_k, 0);
    chk("abort_even", even, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen_done |= int'(done);
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_idle", busy, 0);
    classify(2, 1, 0, 1, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/num_classifier_seq.md
NUM_CLASSIFIER_SEQ -- requirements
Module: num_classifier_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand width; legal range 2..16.
REQ-002 SHALL have parameter DIV_K, default 3, divisibility-test constant; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to classify n_in; sampled only in IDLE.
REQ-006 SHALL have port n_in  input  WIDTH  unsigned operand, captured on start acceptance.
REQ-007 SHALL have port busy  output  1  high from the cycle after acceptance until done inclusive.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking new results.
REQ-009 SHALL have port prime  output  1  registered; 1 iff captured n is prime.
REQ-010 SHALL have port div_k  output  1  registered; 1 iff captured n mod DIV_K == 0 (0 counts as divisible).
REQ-011 SHALL have port even  output  1  registered; 1 iff captured n[0] == 0.

Function
REQ-012 SHALL implement FSM states IDLE, MODK, TRIAL, DONE.
REQ-013 In IDLE with start=1, SHALL capture n_in, issue a modulo op n mod DIV_K, and enter MODK; start outside IDLE SHALL be ignored.
REQ-014 Each modulo op SHALL take exactly WIDTH+1 cycles: 1 load cycle plus WIDTH restoring shift-subtract cycles.
REQ-015 On MODK completion: div_k_next = (rem==0); n<2 -> not prime; n==2 or 3 -> prime; n even -> not prime; otherwise set d=3 and enter TRIAL.
REQ-016 In TRIAL, before each op: if d*d > n (2*WIDTH-bit compare, no overflow) -> prime, else issue n mod d.
REQ-017 On TRIAL op completion: rem==0 -> not prime; else d=d+2 and repeat REQ-016.
REQ-018 On decision, SHALL enter DONE for exactly one cycle: done=1, prime/div_k/even updated on entry, then return to IDLE.
REQ-019 prime, div_k, even SHALL hold their values from DONE until the next DONE.
REQ-020 Latency from start-acceptance edge to done=1 SHALL be M*(WIDTH+1)+1 cycles, M = number of modulo ops performed.
REQ-021 Back-to-back: start high in the IDLE cycle following DONE SHALL be accepted.

Reset
REQ-022 On reset assertion, SHALL immediately force state IDLE, busy=0, done=0, prime=0, div_k=0, even=0, and clear d, captured n and divider state.
REQ-023 Reset mid-operation SHALL abort the operation with no done pulse; the first start after deassertion SHALL be processed normally.

Structure
REQ-024 A shared package/header SHALL hold the FSM state encoding and WIDTH min/max constants.
REQ-025 Modulo logic SHALL be the sub-module mod_serial (clk, reset, load, dividend, divisor, rem, rdy), restoring bit-serial, rdy a one-cycle pulse.
REQ-026 Total RTL SHALL be 120-400 lines including mod_serial.

Verification (WIDTH=5, DIV_K=3)
REQ-027 n=0 -> after 7 cycles done=1, prime=0, div_k=1, even=1.
REQ-028 n=25 -> M=3 (mods by 3, 3, 5), done after 19 cycles, prime=0, div_k=0, even=0.
REQ-029 n=31 -> M=3 (mods by 3, 3, 5; 7*7>31 stops), done after 19 cycles, prime=1, div_k=0, even=0.
REQ-030 Exhaustive n=0..31 -> prime set exactly for {2,3,5,7,11,13,17,19,23,29,31}; div_k exactly for multiples of 3; each latency matches REQ-020.
REQ-031 Start n=29, pulse start with n=6 while busy, then reset at cycle 10 -> n=6 ignored, no done, outputs 0; next start n=2 -> prime=1, even=1, div_k=0 after 7 cycles.
